reflet_vga_txt_writer: RTL

Character-stream front end for the VGA text renderer. It accepts bytes over a valid/ready handshake, keeps a cursor, interprets a few control codes and drives the renderer's text write port (cell coordinates, char, fg/bg colours). It also runs a full-screen clear sequencer, so a CPU or UART only has to push bytes.

---
 rtl/reflet_vga_txt_writer_pkg.sv | 33 +++
 rtl/reflet_vga_txt_writer_if.sv | 44 ++++
 rtl/reflet_vga_txt_writer_cursor.sv | 74 +++++++
 rtl/reflet_vga_txt_writer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/reflet_vga_txt_writer_pkg.sv
// reflet_vga_txt_writer_pkg
// Shared constants for the VGA text path. It holds the font cell size and the
// control codes that the character-stream writer interprets. It also defines
// the writer FSM state type.
// Optional feature macro: REFLET_VGA_TXT_WRITER_LINE_CLEAR_EN adds the
// ST_LINE_CLEAR state.
package reflet_vga_txt_writer_pkg;

  localparam int FONT_WIDTH  = 8;
  localparam int FONT_HEIGHT = 8;

  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
`ifdef REFLET_VGA_TXT_WRITER_LINE_CLEAR_EN
    ST_CLEAR      = 2'd1,
    ST_LINE_CLEAR = 2'd2
`else
    ST_CLEAR      = 2'd1
`endif
  } state_t;

  // True for bytes that move the cursor or start a clear instead of being drawn.
  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == CHR_LF) || (c == CHR_CR) || (c == CHR_BS) || (c == CHR_FF);
  endfunction

endpackage

// File: rtl/reflet_vga_txt_writer_if.sv
// reflet_vga_txt_writer_if
// This interface bundles the writer's byte handshake, colour inputs, clear
// request, text-memory write port and cursor position.
//   slave  : the writer. It takes bytes and colours in, and drives the write
//            port and cursor out.
//   master : the byte source and renderer side.
// Parameters: H_W column width, V_W row width, CD bits per colour channel.
interface reflet_vga_txt_writer_if #(
  parameter int H_W = 7,
  parameter int V_W = 6,
  parameter int CD  = 8
) ();
  logic [7:0]     char_in;
  logic           char_valid;
  logic           char_ready;
  logic [CD-1:0]  R_fg_in, G_fg_in, B_fg_in;
  logic [CD-1:0]  R_bg_in, G_bg_in, B_bg_in;
  logic           clear_req;
  logic           busy;
  logic           write_en;
  logic [H_W-1:0] h_txt_out;
  logic [V_W-1:0] v_txt_out;
  logic [7:0]     char_out;
  logic [CD-1:0]  R_fg_out, G_fg_out, B_fg_out;
  logic [CD-1:0]  R_bg_out, G_bg_out, B_bg_out;
  logic [H_W-1:0] cursor_h;
  logic [V_W-1:0] cursor_v;

  modport slave (
    input  char_in, char_valid, R_fg_in, G_fg_in, B_fg_in,
           R_bg_in, G_bg_in, B_bg_in, clear_req,
    output char_ready, busy, write_en, h_txt_out, v_txt_out, char_out,
           R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
           cursor_h, cursor_v
  );

  modport master (
    output char_in, char_valid, R_fg_in, G_fg_in, B_fg_in,
           R_bg_in, G_bg_in, B_bg_in, clear_req,
    input  char_ready, busy, write_en, h_txt_out, v_txt_out, char_out,
           R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
           cursor_h, cursor_v
  );
endinterface

// File: rtl/reflet_vga_txt_writer_cursor.sv
// reflet_vga_txt_writer_cursor
// This module holds the text cursor as column/row counters.
// Ports:
//   clk, rst_n         : clock and asynchronous active-low reset
//   advance_i          : step one column, wrapping to the next row
//   newline_i          : column 0, next row
//   cr_i               : column 0
//   bs_i               : one column back, saturating at 0
//   home_i             : return to (0,0); takes priority over all other moves
//   col_o, row_o       : registered cursor position
//   new_row_o          : combinational; high when this cycle's move lands on a new row
// Rows wrap from ROWS-1 back to 0. There is no scrolling.
module reflet_vga_txt_writer_cursor #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int H_W  = 7,
  parameter int V_W  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           advance_i,
  input  logic           newline_i,
  input  logic           cr_i,
  input  logic           bs_i,
  input  logic           home_i,
  output logic [H_W-1:0] col_o,
  output logic [V_W-1:0] row_o,
  output logic           new_row_o
);
  logic [H_W-1:0] col_q, col_d;
  logic [V_W-1:0] row_q, row_d;
  logic [V_W-1:0] row_inc;

  assign row_inc = (row_q == V_W'(ROWS - 1)) ? '0 : row_q + V_W'(1);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    new_row_o = 1'b0;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (newline_i) begin
      col_d     = '0;
      row_d     = row_inc;
      new_row_o = 1'b1;
    end else if (cr_i) begin
      col_d = '0;
    end else if (bs_i) begin
      if (col_q != '0) col_d = col_q - H_W'(1);
    end else if (advance_i) begin
      if (col_q == H_W'(COLS - 1)) begin
        col_d     = '0;
        row_d     = row_inc;
        new_row_o = 1'b1;
      end else begin
        col_d = col_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
endmodule

// File: rtl/reflet_vga_txt_writer.sv
// reflet_vga_txt_writer
// This is the character-stream front end for the VGA text renderer. It takes
// bytes over a valid/ready handshake and interprets LF/CR/BS/FF. It drives the
// registered text-memory write port, and runs the full-screen clear sequencer.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : reflet_vga_txt_writer_if.slave, which carries the byte handshake,
//           colours, clear_req, busy, the write port and the cursor position
// Optional feature macro: REFLET_VGA_TXT_WRITER_LINE_CLEAR_EN. When it is
// defined, every move onto a new row by LF or wrap blanks that row.
module reflet_vga_txt_writer
  import reflet_vga_txt_writer_pkg::*;
#(
  parameter int h_size        = 640,
  parameter int v_size        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  reflet_vga_txt_writer_if.slave bus
);
  localparam int COLS = h_size / FONT_WIDTH / (2 ** bit_reduction);
  localparam int ROWS = v_size / FONT_HEIGHT / (2 ** bit_reduction);
  localparam int H_W  = $clog2(COLS);
  localparam int V_W  = $clog2(ROWS);
  localparam int CD   = color_depth;

  state_t         state_q;
  logic           busy_q, write_en_q;
  logic [H_W-1:0] h_q, clr_h_q;
  logic [V_W-1:0] v_q, clr_v_q;
  logic [7:0]     char_q;
  logic [CD-1:0]  r_fg_q, g_fg_q, b_fg_q, r_bg_q, g_bg_q, b_bg_q;
  logic [CD-1:0]  r_lat_q, g_lat_q, b_lat_q;

  logic [H_W-1:0] cur_col;
  logic [V_W-1:0] cur_row, fill_row;
  logic           new_row, accept, printable, clear_start, clear_done, fill_last;

  // Ready is gated by reset so that it reads 0 while the block is held in reset.
  assign bus.char_ready = reset & (state_q == ST_IDLE) & ~bus.clear_req;
  assign accept      = bus.char_valid & bus.char_ready;
  assign printable   = ~is_ctrl(bus.char_in);
  assign clear_start = (state_q == ST_IDLE) &
                       (bus.clear_req | (accept & (bus.char_in == CHR_FF)));
  assign fill_last   = (clr_h_q == H_W'(COLS - 1));
  assign clear_done  = (state_q == ST_CLEAR) & fill_last & (clr_v_q == V_W'(ROWS - 1));

`ifdef REFLET_VGA_TXT_WRITER_LINE_CLEAR_EN
  // A line clear blanks the row the cursor has just moved onto.
  assign fill_row = (state_q == ST_CLEAR) ? clr_v_q : cur_row;
`else
  logic unused_new_row;
  assign unused_new_row = new_row;
  assign fill_row       = clr_v_q;
`endif

  reflet_vga_txt_writer_cursor #(
    .COLS(COLS), .ROWS(ROWS), .H_W(H_W), .V_W(V_W)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (reset),
    .advance_i (accept & printable),
    .newline_i (accept & (bus.char_in == CHR_LF)),
    .cr_i      (accept & (bus.char_in == CHR_CR)),
    .bs_i      (accept & (bus.char_in == CHR_BS)),
    .home_i    (clear_done),
    .col_o     (cur_col),
    .row_o     (cur_row),
    .new_row_o (new_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      write_en_q <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      char_q     <= '0;
      r_fg_q     <= '0;
      g_fg_q     <= '0;
      b_fg_q     <= '0;
      r_bg_q     <= '0;
      g_bg_q     <= '0;
      b_bg_q     <= '0;
      r_lat_q    <= '0;
      g_lat_q    <= '0;
      b_lat_q    <= '0;
      clr_h_q    <= '0;
      clr_v_q    <= '0;
    end else begin
      write_en_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (clear_start) begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
          clr_h_q <= '0;
          clr_v_q <= '0;
          r_lat_q <= bus.R_bg_in;
          g_lat_q <= bus.G_bg_in;
          b_lat_q <= bus.B_bg_in;
        end else if (accept) begin
          r_lat_q <= bus.R_bg_in;
          g_lat_q <= bus.G_bg_in;
          b_lat_q <= bus.B_bg_in;
          if (printable) begin
            write_en_q <= 1'b1;
            h_q        <= cur_col;
            v_q        <= cur_row;
            char_q     <= bus.char_in;
            r_fg_q     <= bus.R_fg_in;
            g_fg_q     <= bus.G_fg_in;
            b_fg_q     <= bus.B_fg_in;
            r_bg_q     <= bus.R_bg_in;
            g_bg_q     <= bus.G_bg_in;
            b_bg_q     <= bus.B_bg_in;
          end
`ifdef REFLET_VGA_TXT_WRITER_LINE_CLEAR_EN
          if (new_row) begin
            state_q <= ST_LINE_CLEAR;
            busy_q  <= 1'b1;
            clr_h_q <= '0;
          end
`endif
        end
      end else begin
        // Fill states write one blank cell per cycle in the latched bg colour.
        write_en_q <= 1'b1;
        h_q        <= clr_h_q;
        v_q        <= fill_row;
        char_q     <= CHR_SPACE;
        r_fg_q     <= r_lat_q;
        g_fg_q     <= g_lat_q;
        b_fg_q     <= b_lat_q;
        r_bg_q     <= r_lat_q;
        g_bg_q     <= g_lat_q;
        b_bg_q     <= b_lat_q;
        if (fill_last) begin
          clr_h_q <= '0;
          if ((state_q != ST_CLEAR) || (clr_v_q == V_W'(ROWS - 1))) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_v_q <= clr_v_q + V_W'(1);
          end
        end else begin
          clr_h_q <= clr_h_q + H_W'(1);
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.write_en  = write_en_q;
  assign bus.h_txt_out = h_q;
  assign bus.v_txt_out = v_q;
  assign bus.char_out  = char_q;
  assign bus.R_fg_out  = r_fg_q;
  assign bus.G_fg_out  = g_fg_q;
  assign bus.B_fg_out  = b_fg_q;
  assign bus.R_bg_out  = r_bg_q;
  assign bus.G_bg_out  = g_bg_q;
  assign bus.B_bg_out  = b_bg_q;
  assign bus.cursor_h  = cur_col;
  assign bus.cursor_v  = cur_row;
endmodule
